// File: rtl/bcd_display_scanner.sv
// Multiplexed 4-digit common 7-segment scanner fed by a valid/ready BCD stream.
// A new value is swapped in only at the frame boundary, so a frame never mixes two values.
module bcd_display_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [6:0]  seg_led,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler_reg;
    logic [1:0]    digit_idx_reg;
    logic [15:0]   display_reg;
    logic [15:0]   pending_reg;
    logic          pending_full_reg;

    logic          tick;
    logic          wrap;
    logic          accept;
    logic [3:0]    upper_zero;
    logic [3:0]    digit_code;
    logic          lz_blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign tick      = (prescaler_reg == PW'(SCAN_DIV - 1));
    assign wrap      = tick && (digit_idx_reg == 2'd3);
    assign accept    = bcd_valid && !pending_full_reg;
    assign bcd_ready = ~pending_full_reg;

    // upper_zero[i] is set when digits i..3 of the shown value are all zero
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            assign upper_zero[gi] = (display_reg[15:gi*4] == '0);
        end
    endgenerate

    assign digit_code = display_reg[digit_idx_reg*4 +: 4];
    assign lz_blank   = LZ_BLANK && (digit_idx_reg != 2'd0) && upper_zero[digit_idx_reg];
    assign an_next    = 4'b0001 << digit_idx_reg;

    always_comb begin
        seg_next = 7'b1111111;
        if (!lz_blank) begin
            case (digit_code)
                4'd0:    seg_next = 7'b0000001;
                4'd1:    seg_next = 7'b1111001;
                4'd2:    seg_next = 7'b0010010;
                4'd3:    seg_next = 7'b0000110;
                4'd4:    seg_next = 7'b1001100;
                4'd5:    seg_next = 7'b0100100;
                4'd6:    seg_next = 7'b0100000;
                4'd7:    seg_next = 7'b0001111;
                4'd8:    seg_next = 7'b0000000;
                4'd9:    seg_next = 7'b0000100;
                default: seg_next = 7'b1111111;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            prescaler_reg    <= '0;
            digit_idx_reg    <= 2'd0;
            display_reg      <= 16'h0000;
            pending_reg      <= 16'h0000;
            pending_full_reg <= 1'b0;
            seg_led          <= 7'b1111111;
            an               <= 4'b0000;
            frame_done       <= 1'b0;
        end else begin
            prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
            if (tick) begin
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end
            // A value accepted on the wrap cycle itself waits for the next frame
            if (wrap && pending_full_reg) begin
                display_reg      <= pending_reg;
                pending_full_reg <= 1'b0;
            end else if (accept) begin
                pending_reg      <= bcd_in;
                pending_full_reg <= 1'b1;
            end
            seg_led    <= seg_next;
            an         <= an_next;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=4: one instance with leading-zero
// blanking, one without. Outputs are driven and sampled on the falling edge.
module tb_bcd_display_scanner;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0 = 7'b0000001;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0010010;
    localparam logic [6:0] S_4 = 7'b1001100;
    localparam logic [6:0] S_5 = 7'b0100100;
    localparam logic [6:0] S_9 = 7'b0000100;

    logic        clk_50MHz;
    logic        rst;
    logic [15:0] bcd_in_a, bcd_in_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    bcd_display_scanner #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u_lz (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bcd_in    (bcd_in_a),
        .bcd_valid (valid_a),
        .bcd_ready (ready_a),
        .seg_led   (seg_a),
        .an        (an_a),
        .frame_done(fd_a)
    );

    bcd_display_scanner #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) u_nolz (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .bcd_in    (bcd_in_b),
        .bcd_valid (valid_b),
        .bcd_ready (ready_b),
        .seg_led   (seg_b),
        .an        (an_b),
        .frame_done(fd_b)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    task automatic step();
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        cyc++;
    endtask

    task automatic run_to(input int t);
        int guard = 0;
        while ((cyc % 16) != t && guard < 64) begin
            step();
            guard++;
        end
        if (guard >= 64) begin
            miscompares++;
            $display("FAIL run_to: phase=%0d required=%0d", cyc % 16, t);
        end
    endtask

    task automatic check_ready(input bit sel, input logic exp, input string name);
        logic obs;
        obs = sel ? ready_b : ready_a;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: bcd_ready=%b required=%b", name, obs, exp);
        end
    endtask

    task automatic check_frame(input bit sel, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3, input string name);
        logic [6:0] exp_seg [4];
        logic [6:0] seg;
        logic [3:0] an_obs;
        logic [3:0] an_exp;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        for (int k = 0; k < 4; k++) begin
            run_to(4 * k + 1);
            seg    = sel ? seg_b : seg_a;
            an_obs = sel ? an_b : an_a;
            an_exp = 4'b0001 << k;
            vectors++;
            $display("vec %0d %s digit%0d an=%b seg=%b", vectors, name, k, an_obs, seg);
            if (an_obs !== an_exp || seg !== exp_seg[k]) begin
                miscompares++;
                $display("FAIL %s d%0d: an=%b seg=%b required an=%b seg=%b",
                         name, k, an_obs, seg, an_exp, exp_seg[k]);
            end
        end
    endtask

    task automatic send(input bit sel, input logic [15:0] value, input string name);
        check_ready(sel, 1'b1, {name, "_pre"});
        if (sel) begin bcd_in_b = value; valid_b = 1'b1; end
        else     begin bcd_in_a = value; valid_a = 1'b1; end
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
        check_ready(sel, 1'b0, {name, "_busy"});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        vectors++;
        if (seg_a !== S_BLANK || an_a !== 4'b0000 || ready_a !== 1'b1 || fd_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: seg=%b an=%b ready=%b fd=%b required seg=1111111 an=0000 ready=1 fd=0",
                     seg_a, an_a, ready_a, fd_a);
        end
        rst = 1'b0;
        cyc = 0;
        step();
        vectors++;
        $display("vec %0d reset_first an=%b seg=%b", vectors, an_a, seg_a);
        if (an_a !== 4'b0001 || seg_a !== S_0) begin
            miscompares++;
            $display("FAIL reset_first: an=%b seg=%b required an=0001 seg=0000001", an_a, seg_a);
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        logic       fd_exp;
        for (int i = 0; i < 32; i++) begin
            step();
            an_exp  = 4'b0001 << (((cyc - 1) / 4) % 4);
            seg_exp = (an_exp == 4'b0001) ? S_0 : S_BLANK;
            fd_exp  = ((cyc % 16) == 0);
            vectors++;
            if (an_a !== an_exp || seg_a !== seg_exp || fd_a !== fd_exp ||
                an_b !== an_exp || seg_b !== S_0) begin
                miscompares++;
                $display("FAIL scan cyc%0d: an=%b seg=%b fd=%b an_b=%b seg_b=%b required an=%b seg=%b fd=%b seg_b=%b",
                         cyc, an_a, seg_a, fd_a, an_b, seg_b, an_exp, seg_exp, fd_exp, S_0);
            end
        end
        $display("vec %0d scan 32 cycles", vectors);
    endtask

    task automatic test_update();
        run_to(6);
        send(1'b0, 16'h1905, "update");
        run_to(9);
        vectors++;
        if (seg_a !== S_BLANK || an_a !== 4'b0100) begin
            miscompares++;
            $display("FAIL update_hold d2: an=%b seg=%b required an=0100 seg=1111111", an_a, seg_a);
        end
        run_to(13);
        vectors++;
        if (seg_a !== S_BLANK || an_a !== 4'b1000) begin
            miscompares++;
            $display("FAIL update_hold d3: an=%b seg=%b required an=1000 seg=1111111", an_a, seg_a);
        end
        check_frame(1'b0, S_5, S_0, S_9, S_1, "update_frame");
        check_ready(1'b0, 1'b1, "update_ready_back");
    endtask

    task automatic test_backpressure();
        run_to(6);
        send(1'b0, 16'h0042, "bp");
        bcd_in_a = 16'h0077;
        valid_a  = 1'b1;
        step();
        step();
        valid_a  = 1'b0;
        check_ready(1'b0, 1'b0, "bp_still_busy");
        check_frame(1'b0, S_2, S_4, S_BLANK, S_BLANK, "bp_frame1");
        check_frame(1'b0, S_2, S_4, S_BLANK, S_BLANK, "bp_frame2");
        check_ready(1'b0, 1'b1, "bp_ready_back");
    endtask

    task automatic test_invalid_nolz();
        run_to(6);
        send(1'b1, 16'h0A00, "nolz");
        check_frame(1'b1, S_0, S_0, S_BLANK, S_0, "nolz_frame");
    endtask

    task automatic test_reset_midop();
        run_to(4);
        send(1'b0, 16'h8888, "midrst");
        run_to(9);
        check_ready(1'b0, 1'b0, "midrst_pending");
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (an_a !== 4'b0000 || seg_a !== S_BLANK) begin
            miscompares++;
            $display("FAIL midrst_in_reset: an=%b seg=%b required an=0000 seg=1111111", an_a, seg_a);
        end
        rst = 1'b0;
        cyc = 0;
        check_ready(1'b0, 1'b1, "midrst_ready");
        check_frame(1'b0, S_0, S_BLANK, S_BLANK, S_BLANK, "midrst_frame1");
        check_frame(1'b0, S_0, S_BLANK, S_BLANK, S_BLANK, "midrst_frame2");
        check_ready(1'b0, 1'b1, "midrst_ready_later");
    endtask

    initial begin
        rst      = 1'b1;
        bcd_in_a = 16'h0000;
        bcd_in_b = 16'h0000;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        test_reset();
        test_scan();
        test_update();
        test_backpressure();
        test_invalid_nolz();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
